// File: rtl/fb_access_scheduler_pkg.sv
// Shared video definitions for the framebuffer path and the sync generators.
// Keeping the raster size and the clear-FSM encoding here gives every
// consumer the same timing source.
package fb_access_scheduler_pkg;

    // Default visible raster
    localparam int HPIXEL_DEF = 640;
    localparam int VPIXEL_DEF = 480;
    localparam int FB_WORDS   = HPIXEL_DEF * VPIXEL_DEF;

    // Clear-screen sequencer states
    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clearState_e;

    // Number of framebuffer words for an arbitrary raster size
    function automatic int fbWords(input int hPixel, input int vPixel);
        return hPixel * vPixel;
    endfunction

endpackage

// File: rtl/fb_clear_sequencer.sv
// Full-screen clear sequencer. Walks every framebuffer word once with a
// latched colour, advancing only when the arbiter grants it a slot, so a
// stalled cycle never skips an address.
module fb_clear_sequencer
    import fb_access_scheduler_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int WORDS  = FB_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_color,
    input  logic              i_grant,
    output logic              o_req,
    output logic              o_idle,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    clearState_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] color_q;
    logic              busy_q;
    logic              done_q;

    // Clear FSM: start latches the colour, each granted slot writes one word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= CLR_IDLE;
            addr_q  <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CLR_IDLE: begin
                    if (i_start) begin
                        state_q <= CLR_CLEAR;
                        addr_q  <= '0;
                        color_q <= i_color;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    if (i_grant) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= CLR_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= CLR_IDLE;
            endcase
        end
    end

    assign o_req  = (state_q == CLR_CLEAR);
    assign o_idle = (state_q == CLR_IDLE);
    assign o_addr = addr_q;
    assign o_data = color_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: rtl/fb_access_scheduler.sv
// Time-slot arbiter for the single-port framebuffer RAM. Display scan-out
// owns pixel-enable cycles inside the active area; every other cycle goes
// to the clear sequencer first and then to the draw engine.
module fb_access_scheduler
    import fb_access_scheduler_pkg::*;
#(
    parameter int HPIXEL = HPIXEL_DEF,
    parameter int VPIXEL = VPIXEL_DEF,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_ce,
    input  logic [9:0]        i_hCount,
    input  logic [9:0]        i_vCount,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_err,
    input  logic              i_clear_start,
    input  logic [DATA_W-1:0] i_clear_color,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid
);

    localparam int                WORDS    = fbWords(HPIXEL, VPIXEL);
    localparam logic [9:0]        H_LIM    = 10'(HPIXEL);
    localparam logic [9:0]        V_LIM    = 10'(VPIXEL);
    localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W + 1)'(WORDS);

    logic              activeArea;
    logic              dispSlot;
    logic              wrReady;
    logic              wrFire;
    logic              wrInRange;
    logic              clearReq;
    logic              clearIdle;
    logic [ADDR_W-1:0] clearAddr;
    logic [DATA_W-1:0] clearData;

    logic [ADDR_W-1:0] dispAddr_q;
    logic              pixPending_q;
    logic [DATA_W-1:0] pixData_q;
    logic              pixValid_q;
    logic              wrErr_q;

    logic [ADDR_W-1:0] memAddr;
    logic              memWe;
    logic [DATA_W-1:0] memWdata;

    assign activeArea = (i_hCount < H_LIM) && (i_vCount < V_LIM);
    assign dispSlot   = i_pix_ce && activeArea;
    assign wrReady    = !dispSlot && clearIdle && !i_rst;
    assign wrFire     = i_wr_valid && wrReady;
    assign wrInRange  = ({1'b0, i_wr_addr} < FB_LIMIT);

    fb_clear_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) u_clear (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_clear_start),
        .i_color (i_clear_color),
        .i_grant (!dispSlot),
        .o_req   (clearReq),
        .o_idle  (clearIdle),
        .o_addr  (clearAddr),
        .o_data  (clearData),
        .o_busy  (o_clear_busy),
        .o_done  (o_clear_done)
    );

    // Scan-out address: restarts every vertical blank, advances per read
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dispAddr_q <= '0;
        end else if (i_vCount >= V_LIM) begin
            dispAddr_q <= '0;
        end else if (dispSlot) begin
            dispAddr_q <= dispAddr_q + ADDR_W'(1);
        end
    end

    // Pixel output: capture RAM data the cycle after a read, blank outside
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pixPending_q <= 1'b0;
            pixData_q    <= '0;
            pixValid_q   <= 1'b0;
        end else begin
            pixPending_q <= dispSlot;
            if (pixPending_q) begin
                pixData_q  <= i_mem_rdata;
                pixValid_q <= 1'b1;
            end else if (i_pix_ce && !activeArea) begin
                pixData_q  <= '0;
                pixValid_q <= 1'b0;
            end
        end
    end

    // Out-of-range draw writes are swallowed and flagged one cycle later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrErr_q <= 1'b0;
        end else begin
            wrErr_q <= wrFire && !wrInRange;
        end
    end

    // RAM port mux: display read, then clear write, then draw write
    always_comb begin
        memAddr  = dispAddr_q;
        memWe    = 1'b0;
        memWdata = '0;
        if (dispSlot) begin
            memAddr = dispAddr_q;
        end else if (clearReq) begin
            memAddr  = clearAddr;
            memWe    = 1'b1;
            memWdata = clearData;
        end else if (wrFire && wrInRange) begin
            memAddr  = i_wr_addr;
            memWe    = 1'b1;
            memWdata = i_wr_data;
        end
    end

    assign o_wr_ready  = wrReady;
    assign o_wr_err    = wrErr_q;
    assign o_mem_addr  = memAddr;
    assign o_mem_we    = memWe;
    assign o_mem_wdata = memWdata;
    assign o_pix_data  = pixData_q;
    assign o_pix_valid = pixValid_q;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Bench for the framebuffer access scheduler on a tiny 8x4 raster, with a
// behavioural RAM and a write monitor standing in for the real memory.
module tb_fb_access_scheduler;

   localparam int HP  = 8;
   localparam int VP  = 4;
   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int FBW = HP * VP;

   logic          clk = 1'b0;
   logic          rst;
   logic          pixCe;
   logic [9:0]    hCount;
   logic [9:0]    vCount;
   logic          wrValid;
   logic          wrReady;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;
   logic          wrErr;
   logic          clearStart;
   logic [DW-1:0] clearColor;
   logic          clearBusy;
   logic          clearDone;
   logic [AW-1:0] memAddr;
   logic          memWe;
   logic [DW-1:0] memWdata;
   logic [DW-1:0] memRdata;
   logic [DW-1:0] pixData;
   logic          pixValid;

   logic [7:0]    ram [0:255];
   logic [7:0]    expMem [0:255];
   logic          preload;
   logic [15:0]   logQ [$];

   int total;
   int bad;

   fb_access_scheduler #(
      .HPIXEL (HP),
      .VPIXEL (VP),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pix_ce      (pixCe),
      .i_hCount      (hCount),
      .i_vCount      (vCount),
      .i_wr_valid    (wrValid),
      .o_wr_ready    (wrReady),
      .i_wr_addr     (wrAddr),
      .i_wr_data     (wrData),
      .o_wr_err      (wrErr),
      .i_clear_start (clearStart),
      .i_clear_color (clearColor),
      .o_clear_busy  (clearBusy),
      .o_clear_done  (clearDone),
      .o_mem_addr    (memAddr),
      .o_mem_we      (memWe),
      .o_mem_wdata   (memWdata),
      .i_mem_rdata   (memRdata),
      .o_pix_data    (pixData),
      .o_pix_valid   (pixValid)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // Single-port RAM with one-cycle read latency, optionally preloaded with addr[7:0]
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
      end else if (memWe) begin
         ram[memAddr] <= memWdata;
      end
      memRdata <= ram[memAddr];
   end

   // Record every RAM write as {addr, data}
   always @(posedge clk) begin
      if (memWe) logQ.push_back({memAddr, memWdata});
   end

   // Hard stop in case something never settles
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic setIn(input logic ce, input int h, input int v);
      pixCe  = ce;
      hCount = 10'(h);
      vCount = 10'(v);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk) setIn(1'b1, k, 0);
         @(negedge clk) setIn(1'b0, k, 0);
      end
      @(negedge clk) setIn(1'b0, 20, 0);
      clearStart = 1'b1;
      clearColor = 8'h5A;
      @(negedge clk) clearStart = 1'b0;
      wrValid = 1'b1;
      wrAddr  = 8'd3;
      #1;
      total++; if (clearBusy !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_busy got=%0b exp=1", clearBusy); end
      total++; if (pixValid !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_pixValid got=%0b exp=1", pixValid); end
      #1 rst = 1'b1;
      #1;
      total++; if (memAddr !== 8'd0) begin bad++; $display("[TB] FAIL reset_memAddr got=%0h exp=0", memAddr); end
      total++; if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL reset_memWe got=%0b exp=0", memWe); end
      total++; if (memWdata !== 8'd0) begin bad++; $display("[TB] FAIL reset_memWdata got=%0h exp=0", memWdata); end
      total++; if (pixData !== 8'd0) begin bad++; $display("[TB] FAIL reset_pixData got=%0h exp=0", pixData); end
      total++; if (pixValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pixValid got=%0b exp=0", pixValid); end
      total++; if (wrErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrErr got=%0b exp=0", wrErr); end
      total++; if (clearBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", clearBusy); end
      total++; if (clearDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b exp=0", clearDone); end
      total++; if (wrReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrReady got=%0b exp=0", wrReady); end
      wrValid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk) setIn(1'b1, 0, 0);
      #1;
      total++; if ({memWe, memAddr} !== {1'b0, 8'd0}) begin bad++; $display("[TB] FAIL reset_first_read got=%0b/%0h exp=0/0", memWe, memAddr); end
      @(negedge clk) setIn(1'b0, 20, 0);
   endtask

   task automatic test_scanout();
      @(negedge clk) setIn(1'b0, 20, 4);
      preload = 1'b1;
      @(negedge clk) preload = 1'b0;
      setIn(1'b1, 20, 4);
      @(negedge clk) setIn(1'b0, 20, 4);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk) setIn(1'b1, k, 0);
         #1;
         total++; if ({memWe, memAddr} !== {1'b0, 8'(k)}) begin bad++; $display("[TB] FAIL scan_read_addr got=%0b/%0h exp=0/%0h", memWe, memAddr, k); end
         @(negedge clk) setIn(1'b0, k, 0);
         @(posedge clk) #1;
         total++; if ({pixValid, pixData} !== {1'b1, 8'(k)}) begin bad++; $display("[TB] FAIL scan_pixel got=%0b/%0h exp=1/%0h", pixValid, pixData, k); end
      end
      @(negedge clk) setIn(1'b1, HP, 0);
      #1;
      total++; if ({pixValid, pixData} !== {1'b1, 8'd5}) begin bad++; $display("[TB] FAIL scan_hold got=%0b/%0h exp=1/5", pixValid, pixData); end
      @(posedge clk) #1;
      total++; if ({pixValid, pixData} !== 9'd0) begin bad++; $display("[TB] FAIL scan_blank got=%0b/%0h exp=0/0", pixValid, pixData); end
   endtask

   task automatic test_draw_contention();
      @(negedge clk) setIn(1'b1, 2, 0);
      logQ.delete();
      wrValid = 1'b1;
      wrAddr  = 8'd20;
      wrData  = 8'hAA;
      #1;
      total++; if ({wrReady, memWe} !== 2'b00) begin bad++; $display("[TB] FAIL draw_ce_blocked got=%0b/%0b exp=0/0", wrReady, memWe); end
      @(negedge clk) setIn(1'b0, 2, 0);
      #1;
      total++; if (wrReady !== 1'b1) begin bad++; $display("[TB] FAIL draw_ready got=%0b exp=1", wrReady); end
      total++; if ({memWe, memAddr, memWdata} !== {1'b1, 8'd20, 8'hAA}) begin bad++; $display("[TB] FAIL draw_write got=%0b/%0h/%0h exp=1/14/aa", memWe, memAddr, memWdata); end
      @(negedge clk) wrValid = 1'b0;
      setIn(1'b0, 20, 4);
      repeat (2) @(negedge clk);
      total++; if (logQ.size() !== 1) begin bad++; $display("[TB] FAIL draw_write_count got=%0d exp=1", logQ.size()); end
      else begin
         total++; if (logQ[0] !== {8'd20, 8'hAA}) begin bad++; $display("[TB] FAIL draw_write_entry got=%0h exp=14aa", logQ[0]); end
      end
   endtask

   task automatic test_clear();
      int busyCycles = 0;
      int doneCount  = 0;
      int readyBad   = 0;
      int fallBad    = 0;
      int entryBad   = 0;
      logic prevBusy;
      @(negedge clk) setIn(1'b0, 20, 4);
      logQ.delete();
      clearStart = 1'b1;
      clearColor = 8'h1F;
      @(negedge clk) clearStart = 1'b0;
      #1;
      total++; if (clearBusy !== 1'b1) begin bad++; $display("[TB] FAIL clear_busy_rise got=%0b exp=1", clearBusy); end
      prevBusy = clearBusy;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         setIn(1'(c % 2), 20, 4);
         clearStart = (c == 5);
         clearColor = 8'h33;
         #1;
         if (clearBusy) busyCycles++;
         if (clearBusy && wrReady) readyBad++;
         if (clearDone) begin
            doneCount++;
            if (!(prevBusy && !clearBusy)) fallBad++;
         end
         prevBusy = clearBusy;
      end
      clearStart = 1'b0;
      total++; if (busyCycles !== FBW) begin bad++; $display("[TB] FAIL clear_busy_cycles got=%0d exp=%0d", busyCycles, FBW); end
      total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL clear_done_count got=%0d exp=1", doneCount); end
      total++; if (fallBad !== 0) begin bad++; $display("[TB] FAIL clear_done_vs_busy got=%0d exp=0", fallBad); end
      total++; if (readyBad !== 0) begin bad++; $display("[TB] FAIL clear_ready_while_busy got=%0d exp=0", readyBad); end
      total++; if (logQ.size() !== FBW) begin bad++; $display("[TB] FAIL clear_write_count got=%0d exp=%0d", logQ.size(), FBW); end
      else begin
         for (int i = 0; i < FBW; i++) if (logQ[i] !== {8'(i), 8'h1F}) entryBad++;
         total++; if (entryBad !== 0) begin bad++; $display("[TB] FAIL clear_write_seq got=%0d exp=0", entryBad); end
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clk) setIn(1'b0, 20, 4);
      logQ.delete();
      wrValid = 1'b1;
      wrAddr  = 8'(FBW);
      wrData  = 8'h55;
      #1;
      total++; if ({wrReady, memWe} !== 2'b10) begin bad++; $display("[TB] FAIL oor_accept got=%0b/%0b exp=1/0", wrReady, memWe); end
      @(posedge clk) #1;
      wrValid = 1'b0;
      total++; if (wrErr !== 1'b1) begin bad++; $display("[TB] FAIL oor_err_pulse got=%0b exp=1", wrErr); end
      @(posedge clk) #1;
      total++; if (wrErr !== 1'b0) begin bad++; $display("[TB] FAIL oor_err_end got=%0b exp=0", wrErr); end
      total++; if (logQ.size() !== 0) begin bad++; $display("[TB] FAIL oor_no_write got=%0d exp=0", logQ.size()); end
   endtask

   task automatic test_reset_mid_clear();
      logic found = 1'b0;
      int   doneSeen = 0;
      int   entryBad = 0;
      @(negedge clk) setIn(1'b0, 20, 4);
      clearStart = 1'b1;
      clearColor = 8'h2C;
      @(negedge clk) clearStart = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (memWe && memAddr == 8'd10) begin found = 1'b1; break; end
         @(negedge clk);
      end
      total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL midclr_reach10 got=%0b exp=1", found); end
      #1 rst = 1'b1;
      #1;
      total++; if ({clearBusy, clearDone, memWe} !== 3'b000) begin bad++; $display("[TB] FAIL midclr_reset got=%0b%0b%0b exp=000", clearBusy, clearDone, memWe); end
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk) #1;
         if (clearDone) doneSeen++;
      end
      total++; if (doneSeen !== 0) begin bad++; $display("[TB] FAIL midclr_no_done got=%0d exp=0", doneSeen); end
      @(negedge clk) logQ.delete();
      clearStart = 1'b1;
      clearColor = 8'h4D;
      @(negedge clk) clearStart = 1'b0;
      repeat (40) @(negedge clk);
      total++; if (logQ.size() !== FBW) begin bad++; $display("[TB] FAIL midclr_restart_count got=%0d exp=%0d", logQ.size(), FBW); end
      else begin
         for (int i = 0; i < FBW; i++) if (logQ[i] !== {8'(i), 8'h4D}) entryBad++;
         total++; if (entryBad !== 0) begin bad++; $display("[TB] FAIL midclr_restart_seq got=%0d exp=0", entryBad); end
      end
   endtask

   task automatic test_random();
      logic       errPrev = 1'b0;
      logic       errNext;
      logic       accepted;
      logic       slot;
      logic       pend = 1'b0;
      logic [7:0] readVal = 8'd0;
      logic [7:0] expAddr;
      int         v;
      for (int i = 0; i < 256; i++) expMem[i] = 8'(i);
      @(negedge clk) setIn(1'b0, 20, 4);
      wrValid = 1'b0;
      preload = 1'b1;
      @(negedge clk) preload = 1'b0;
      for (int r = 0; r < 12; r++) begin
         v = (r + 4) % 6;
         for (int h = 0; h < 12; h++) begin
            for (int ph = 0; ph < 2; ph++) begin
               @(negedge clk) setIn(1'(ph == 0), h, v);
               if (!wrValid && $urandom_range(0, 2) == 0) begin
                  wrValid = 1'b1;
                  wrAddr  = 8'($urandom_range(0, 39));
                  wrData  = 8'($urandom);
               end
               #1;
               slot     = (ph == 0) && (h < HP) && (v < VP);
               accepted = 1'b0;
               errNext  = 1'b0;
               total++; if (wrReady !== !slot) begin bad++; $display("[TB] FAIL rnd_ready got=%0b exp=%0b v=%0d h=%0d", wrReady, !slot, v, h); end
               if (slot) begin
                  expAddr = 8'(v * HP + h);
                  total++; if ({memWe, memAddr} !== {1'b0, expAddr}) begin bad++; $display("[TB] FAIL rnd_read got=%0b/%0h exp=0/%0h", memWe, memAddr, expAddr); end
                  readVal = expMem[expAddr];
                  pend    = 1'b1;
               end else if (wrValid) begin
                  accepted = 1'b1;
                  if (wrAddr < 8'(FBW)) begin
                     total++; if ({memWe, memAddr, memWdata} !== {1'b1, wrAddr, wrData}) begin bad++; $display("[TB] FAIL rnd_write got=%0b/%0h/%0h exp=1/%0h/%0h", memWe, memAddr, memWdata, wrAddr, wrData); end
                     expMem[wrAddr] = wrData;
                  end else begin
                     total++; if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL rnd_oor_we got=%0b exp=0", memWe); end
                     errNext = 1'b1;
                  end
               end else begin
                  total++; if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL rnd_idle_we got=%0b exp=0", memWe); end
               end
               total++; if (wrErr !== errPrev) begin bad++; $display("[TB] FAIL rnd_err got=%0b exp=%0b", wrErr, errPrev); end
               @(posedge clk) #1;
               if (accepted) wrValid = 1'b0;
               errPrev = errNext;
               if (ph == 1 && pend) begin
                  pend = 1'b0;
                  total++; if ({pixValid, pixData} !== {1'b1, readVal}) begin bad++; $display("[TB] FAIL rnd_pixel got=%0b/%0h exp=1/%0h", pixValid, pixData, readVal); end
               end else if (ph == 0 && !((h < HP) && (v < VP))) begin
                  total++; if ({pixValid, pixData} !== 9'd0) begin bad++; $display("[TB] FAIL rnd_blank got=%0b/%0h exp=0/0", pixValid, pixData); end
               end
            end
         end
      end
      wrValid = 1'b0;
   endtask

   // Test sequence
   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      preload    = 1'b1;
      pixCe      = 1'b0;
      hCount     = 10'd20;
      vCount     = 10'd4;
      wrValid    = 1'b0;
      wrAddr     = '0;
      wrData     = '0;
      clearStart = 1'b0;
      clearColor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      rst     = 1'b0;
      $display("[TB] starting");
      test_reset();
      test_scanout();
      test_draw_contention();
      test_clear();
      test_out_of_range();
      test_reset_mid_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
